// File: rtl/axil_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axil_regfile
// Description : AXI4-Lite slave register file with live register outputs.
//               Define AXIL_REGFILE_WSTRB_EN for byte-strobe write merging.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_regfile #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        NUM_REGS       = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    output logic [AXI_DATA_WIDTH-1:0]   reg_out [NUM_REGS]
);

    localparam int c_STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int c_ADDR_LSB = $clog2(c_STRB_W);
    localparam int c_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] c_NUM_REGS = AXI_ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [0:0]                r_wstate, w_wstate_nxt;
    logic [0:0]                r_rstate, w_rstate_nxt;
    logic                      r_aw_held, r_w_held;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [1:0]                r_bresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_commit;

    // Extra MSB of the difference is the borrow: set when addr < BASE_ADDR.
    logic [AXI_ADDR_WIDTH:0]   w_aw_diff, w_ar_diff;
    logic [AXI_ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx;
    logic [c_IDX_W-1:0]        w_aw_sel, w_ar_sel;
    logic                      w_aw_ok, w_ar_ok;

    assign w_aw_diff = {1'b0, r_awaddr} - {1'b0, BASE_ADDR};
    assign w_ar_diff = {1'b0, s_axil_araddr} - {1'b0, BASE_ADDR};
    assign w_aw_idx  = w_aw_diff[AXI_ADDR_WIDTH-1:0] >> c_ADDR_LSB;
    assign w_ar_idx  = w_ar_diff[AXI_ADDR_WIDTH-1:0] >> c_ADDR_LSB;
    assign w_aw_sel  = w_aw_idx[c_IDX_W-1:0];
    assign w_ar_sel  = w_ar_idx[c_IDX_W-1:0];
    assign w_aw_ok   = !w_aw_diff[AXI_ADDR_WIDTH] && (w_aw_idx < c_NUM_REGS);
    assign w_ar_ok   = !w_ar_diff[AXI_ADDR_WIDTH] && (w_ar_idx < c_NUM_REGS);

    // Ready outputs are gated by areset so they stay low during reset.
    assign s_axil_awready = !areset && (r_wstate == W_IDLE) && !r_aw_held;
    assign s_axil_wready  = !areset && (r_wstate == W_IDLE) && !r_w_held;
    assign s_axil_arready = !areset && (r_rstate == R_IDLE);
    assign s_axil_bvalid  = (r_wstate == W_RESP);
    assign s_axil_rvalid  = (r_rstate == R_RESP);
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;

    assign w_aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_w_hs   = s_axil_wvalid && s_axil_wready;
    assign w_ar_hs  = s_axil_arvalid && s_axil_arready;
    assign w_commit = (r_wstate == W_IDLE) && r_aw_held && r_w_held;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axil_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
            R_RESP:  if (s_axil_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_bresp   <= '0;
        end else begin
            if (w_aw_hs) begin
                r_awaddr  <= s_axil_awaddr;
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata  <= s_axil_wdata;
                r_w_held <= 1'b1;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_aw_ok ? c_OKAY : c_SLVERR;
            end
        end
    end

`ifdef AXIL_REGFILE_WSTRB_EN
    logic [c_STRB_W-1:0] r_wstrb;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstrb <= '0;
        end else if (w_w_hs) begin
            r_wstrb <= s_axil_wstrb;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && w_aw_ok) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (r_wstrb[b]) r_regs[w_aw_sel][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end
`else
    logic w_unused_wstrb;
    assign w_unused_wstrb = ^s_axil_wstrb;

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && w_aw_ok) begin
            r_regs[w_aw_sel] <= r_wdata;
        end
    end
`endif

    // Read samples r_regs before any same-edge commit lands (pre-write value).
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rdata <= '0;
            r_rresp <= '0;
        end else if (w_ar_hs) begin
            r_rdata <= w_ar_ok ? r_regs[w_ar_sel] : '0;
            r_rresp <= w_ar_ok ? c_OKAY : c_SLVERR;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[gi] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axil_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_regfile
// Description : Self-checking bench for axil_regfile (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_regfile;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] reg_out [NR];

    always #5 aclk = ~aclk;

    axil_regfile #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .NUM_REGS      (NR),
        .BASE_ADDR     (32'h0000_0000)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axil_awaddr (awaddr),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata  (wdata),
        .s_axil_wstrb  (wstrb),
        .s_axil_wvalid (wvalid),
        .s_axil_wready (wready),
        .s_axil_bresp  (bresp),
        .s_axil_bvalid (bvalid),
        .s_axil_bready (bready),
        .s_axil_araddr (araddr),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata  (rdata),
        .s_axil_rresp  (rresp),
        .s_axil_rvalid (rvalid),
        .s_axil_rready (rready),
        .reg_out       (reg_out)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    rsp_t        b_q[$];
    rsp_t        r_q[$];
    vec_t        tbl[10];
    logic [31:0] model [NR];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 32'(NR * 4)) begin
`ifdef AXIL_REGFILE_WSTRB_EN
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
`else
            if (strb !== 4'hx) model[addr[5:2]] = data;
`endif
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, output int lat);
        bit   aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire, got = 1'b0;
        rsp_t e;
        b_q.push_back('{data: 32'h0, resp: exp_resp});
        if (exp_resp == 2'b00) model_write(addr, data, strb);
        @(negedge aclk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge aclk);
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bvalid) got = 1'b1;
            else begin lat++; @(negedge aclk); end
        end
        e = b_q.pop_front();
        if (got) begin
            check($sformatf("bresp @%0h", addr), bresp, e.resp);
            @(negedge aclk);
        end else begin
            check($sformatf("bvalid timeout @%0h", addr), 0, 1);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit   fired = 1'b0, got = 1'b0;
        rsp_t e;
        r_q.push_back('{data: exp_data, resp: exp_resp});
        @(negedge aclk);
        araddr = addr; arvalid = 1'b1;
        for (int c = 0; c < 20 && !fired; c++) begin
            fired = arready;
            @(negedge aclk);
        end
        arvalid = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (rvalid) got = 1'b1;
            else @(negedge aclk);
        end
        e = r_q.pop_front();
        if (got) begin
            check($sformatf("rdata @%0h", addr), rdata, e.data);
            check($sformatf("rresp @%0h", addr), rresp, e.resp);
            @(negedge aclk);
        end else begin
            check($sformatf("rvalid timeout @%0h", addr), 0, 1);
        end
    endtask

    initial begin
        int lat;
        tbl[0] = '{1'b1, 32'h00, 32'h1111_1111, 4'hF, 2'b00, 32'h0};
        tbl[1] = '{1'b1, 32'h3C, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
        tbl[2] = '{1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF, 2'b10, 32'h0};
        tbl[3] = '{1'b0, 32'h00, 32'h0,         4'h0, 2'b00, 32'h1111_1111};
        tbl[4] = '{1'b0, 32'h3C, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        tbl[5] = '{1'b0, 32'h40, 32'h0,         4'h0, 2'b10, 32'h0};
        tbl[6] = '{1'b0, 32'h3E, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        tbl[7] = '{1'b1, 32'h15, 32'h0000_0055, 4'hF, 2'b00, 32'h0};
        tbl[8] = '{1'b0, 32'h14, 32'h0,         4'h0, 2'b00, 32'h0000_0055};
        tbl[9] = '{1'b0, 32'hFFFF_FFF0, 32'h0,  4'h0, 2'b10, 32'h0};
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        areset = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(negedge aclk);
        check("reset awready", awready, 0);
        check("reset wready",  wready,  0);
        check("reset arready", arready, 0);
        check("reset bvalid",  bvalid,  0);
        check("reset rvalid",  rvalid,  0);
        check("reset rdata",   rdata,   0);
        for (int i = 0; i < NR; i++) check($sformatf("reset reg_out[%0d]", i), reg_out[i], 0);
        areset = 1'b0;
        #1;
        check("post-reset awready", awready, 1);
        check("post-reset arready", arready, 1);

        // Same-cycle AW/W, minimum latency
        axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00, lat);
        check("write latency", lat, 1);
        check("reg_out[2]", reg_out[2], 32'hDEAD_BEEF);
        axi_read(32'h08, 32'hDEAD_BEEF, 2'b00);

        // W three cycles ahead of AW
        @(negedge aclk);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        check("early W wready", wready, 1);
        @(negedge aclk);
        wvalid = 1'b0;
        check("wready after W capture", wready, 0);
        repeat (2) begin
            @(negedge aclk);
            check("no bvalid before AW", bvalid, 0);
        end
        awaddr = 32'h04; awvalid = 1'b1;
        check("late AW awready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        check("bvalid one edge after AW", bvalid, 0);
        @(negedge aclk);
        check("bvalid after commit", bvalid, 1);
        check("bresp late AW", bresp, 2'b00);
        @(negedge aclk);
        model[1] = 32'h1234_5678;
        check("reg_out[1]", reg_out[1], 32'h1234_5678);

        // Strobe merge
        axi_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, lat);
        axi_write(32'h0C, 32'h0000_AB00, 4'b0010, 2'b00, lat);
`ifdef AXIL_REGFILE_WSTRB_EN
        check("wstrb reg_out[3]", reg_out[3], 32'hFFFF_ABFF);
`else
        check("wstrb reg_out[3]", reg_out[3], 32'h0000_AB00);
`endif

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].is_wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, lat);
            else              axi_read(tbl[i].addr, tbl[i].rdata, tbl[i].resp);
        end
        for (int i = 0; i < NR; i++) check($sformatf("model reg_out[%0d]", i), reg_out[i], model[i]);

        // Read handshaken on the commit edge returns the pre-write value
        axi_write(32'h18, 32'h600D_0001, 4'hF, 2'b00, lat);
        @(negedge aclk);
        check("concurrent awready", awready, 1);
        awaddr = 32'h18; wdata = 32'h600D_0002; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("concurrent arready", arready, 1);
        araddr = 32'h18; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        check("concurrent bvalid", bvalid, 1);
        check("concurrent rvalid", rvalid, 1);
        check("concurrent rdata pre-write", rdata, 32'h600D_0001);
        check("concurrent reg_out[6]", reg_out[6], 32'h600D_0002);
        @(negedge aclk);
        model[6] = 32'h600D_0002;

        // bready held low
        bready = 1'b0;
        awaddr = 32'h10; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall bvalid c%0d", c),  bvalid,  1);
            check($sformatf("stall bresp c%0d", c),   bresp,   2'b00);
            check($sformatf("stall awready c%0d", c), awready, 0);
            check($sformatf("stall wready c%0d", c),  wready,  0);
            @(negedge aclk);
        end
        bready = 1'b1;
        @(negedge aclk);
        check("bvalid after bready", bvalid, 0);

        // rready held low
        rready = 1'b0;
        araddr = 32'h10; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall rvalid c%0d", c),  rvalid,  1);
            check($sformatf("stall rdata c%0d", c),   rdata,   32'hCAFE_F00D);
            check($sformatf("stall rresp c%0d", c),   rresp,   2'b00);
            check($sformatf("stall arready c%0d", c), arready, 0);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        check("rvalid after rready", rvalid, 0);

        // Reset with AW held and W pending
        awaddr = 32'h18; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        check("aw held awready", awready, 0);
        wdata = 32'h7777_7777; wvalid = 1'b1; areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0; wvalid = 1'b0;
        #1;
        check("release awready", awready, 1);
        check("release wready",  wready,  1);
        for (int i = 0; i < NR; i++) check($sformatf("mid-reset reg_out[%0d]", i), reg_out[i], 0);
        repeat (5) begin
            @(negedge aclk);
            check("no bvalid after reset", bvalid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
